// File: rtl/axi4_protocol_checker.sv
// axi4_protocol_checker
//   Passive, stateful AXI4 protocol checker for one AXI4 port. It tracks
//   W burst lengths against the AW lengths, counts outstanding writes and
//   reads, watches per-channel VALID-without-READY stalls, and runs a
//   global progress watchdog while transactions are outstanding.
//
// Handshake semantics: a transfer on channel X happens at a rising aclk
//   edge where Xvalid and Xready are both high. The checker never drives
//   the bus; every input is observed only.
//
// Ports:
//   aclk, areset_n        clock, synchronous active-low reset
//   chk_en                0 masks error reporting (tracking still runs)
//   aw*/w*/b*/ar*/r*      observed AXI4 handshake and framing signals
//   err_sticky[7:0]       sticky error flags, bit index = error code
//   err_pulse             high for one cycle after an unmasked error edge
//   err_first[2:0]        code of the first error since reset
//   err_count             saturating count of error events
//   wr_outstanding        writes accepted on AW whose B is not yet seen
//   rd_outstanding        reads accepted on AR whose RLAST is not yet seen
//   dbg_fifo_cnt          AW-length FIFO occupancy (debug)
//   dbg_wbeat             current W beat index within the burst (debug)
module axi4_protocol_checker #(
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int MAX_STALL       = 256,
  parameter int TIMEOUT         = 1024,
  parameter int CNT_W           = 16,
  localparam int OW             = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             chk_en,
  input  logic             awvalid,
  input  logic             awready,
  input  logic [7:0]       awlen,
  input  logic [2:0]       awsize,
  input  logic             wvalid,
  input  logic             wready,
  input  logic             wlast,
  input  logic             bvalid,
  input  logic             bready,
  input  logic             arvalid,
  input  logic             arready,
  input  logic [7:0]       arlen,
  input  logic             rvalid,
  input  logic             rready,
  input  logic             rlast,
  output logic [7:0]       err_sticky,
  output logic             err_pulse,
  output logic [2:0]       err_first,
  output logic [CNT_W-1:0] err_count,
  output logic [OW-1:0]    wr_outstanding,
  output logic [OW-1:0]    rd_outstanding,
  output logic [OW-1:0]    dbg_fifo_cnt,
  output logic [8:0]       dbg_wbeat
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL);
  localparam logic [SW-1:0] STALL_M1  = SW'((MAX_STALL > 0) ? MAX_STALL - 1 : 0);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_M1     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // awsize, arlen and the data width are observed for future checks only.
  logic [STRB_W+10:0] unused_sig;
  assign unused_sig = {{STRB_W{1'b0}}, awsize, arlen};

  logic [7:0]          fifo_q [MAX_OUTSTANDING];
  logic [7:0]          fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [8:0]          wbeat_q, wbeat_d;
  logic [OW-1:0]       wbp_q, wbp_d;
  logic [OW-1:0]       wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [4:0][SW-1:0]  stall_q, stall_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic [7:0]          err_sticky_q, err_sticky_d;
  logic                err_pulse_q, err_pulse_d;
  logic [2:0]          err_first_q, err_first_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;

  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                aw_ok, ar_ok, bypass, have_len, w_beat, burst_end;
  logic [8:0]          exp_len, wbeat_inc;
  logic [4:0]          vld, rdy;
  logic [7:0]          det, e;
  logic [CNT_W:0]      err_sum;
  logic [2:0]          first_idx;

  always_comb begin
    aw_hs = awvalid & awready;
    w_hs  = wvalid & wready;
    b_hs  = bvalid & bready;
    ar_hs = arvalid & arready;
    r_hs  = rvalid & rready;
    vld   = {rvalid, arvalid, bvalid, wvalid, awvalid};
    rdy   = {rready, arready, bready, wready, awready};
    det   = '0;

    // Overflowing AW/AR handshakes are dropped from all tracking.
    aw_ok = aw_hs & (fifo_cnt_q != OUT_MAX) & (wr_out_q != OUT_MAX);
    ar_ok = ar_hs & (rd_out_q != OUT_MAX);
    det[5] = (aw_hs & ~aw_ok) | (ar_hs & ~ar_ok);

    // A W beat arriving with the very first AW uses the incoming awlen.
    bypass    = (fifo_cnt_q == '0) & aw_ok & w_hs;
    have_len  = (fifo_cnt_q != '0) | bypass;
    exp_len   = (fifo_cnt_q == '0) ? ({1'b0, awlen} + 9'd1)
                                   : ({1'b0, fifo_q[rd_ptr_q]} + 9'd1);
    wbeat_inc = wbeat_q + 9'd1;
    w_beat    = w_hs & have_len;
    burst_end = w_beat & (wlast | (wbeat_inc == exp_len));
    det[0]    = w_beat & wlast & (wbeat_inc < exp_len);
    det[1]    = w_beat & ~wlast & (wbeat_inc == exp_len);
    det[2]    = w_hs & ~have_len;

    // Bypass push+pop in the same cycle leaves the FIFO consistently empty.
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (aw_ok) begin
      fifo_d[wr_ptr_q] = awlen;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (burst_end) rd_ptr_d = rd_ptr_q + PW'(1);
    fifo_cnt_d = fifo_cnt_q + OW'(aw_ok) - OW'(burst_end);

    wbeat_d = burst_end ? 9'd0 : (w_beat ? wbeat_inc : wbeat_q);

    // B pending is judged on the registered count, so a B coinciding with
    // the burst end that would have enabled it is still unexpected.
    det[3]   = b_hs & (wbp_q == '0);
    wbp_d    = wbp_q + OW'(burst_end) - OW'(b_hs & (wbp_q != '0));
    wr_out_d = wr_out_q + OW'(aw_ok) - OW'(b_hs & (wr_out_q != '0));

    det[4]   = r_hs & (rd_out_q == '0);
    rd_out_d = rd_out_q + OW'(ar_ok) - OW'(r_hs & rlast & (rd_out_q != '0));

    // Stall counters saturate at the limit so each stall reports once.
    stall_d = stall_q;
    for (int c = 0; c < 5; c++) begin
      if (vld[c] & ~rdy[c]) begin
        if (stall_q[c] != STALL_LIM) stall_d[c] = stall_q[c] + SW'(1);
        if ((MAX_STALL != 0) && (stall_q[c] == STALL_M1)) det[6] = 1'b1;
      end else begin
        stall_d[c] = '0;
      end
    end

    idle_d = '0;
    if (((wr_out_q | rd_out_q) != '0) & ~(aw_hs | w_hs | b_hs | ar_hs | r_hs)) begin
      idle_d = (idle_q != TO_LIM) ? idle_q + TW'(1) : idle_q;
      if ((TIMEOUT != 0) && (idle_q == TO_M1)) det[7] = 1'b1;
    end

    e = det & {8{chk_en}};

    first_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (e[i]) first_idx = 3'(i);
    end

    err_sticky_d = err_sticky_q | e;
    err_pulse_d  = |e;
    // An empty sticky vector means no unmasked error has been seen yet.
    err_first_d  = ((err_sticky_q == '0) && (e != '0)) ? first_idx : err_first_q;
    err_sum      = {1'b0, err_count_q} + (CNT_W + 1)'($countones(e));
    err_count_d  = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      wbeat_q      <= '0;
      wbp_q        <= '0;
      wr_out_q     <= '0;
      rd_out_q     <= '0;
      stall_q      <= '0;
      idle_q       <= '0;
      err_sticky_q <= '0;
      err_pulse_q  <= 1'b0;
      err_first_q  <= '0;
      err_count_q  <= '0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wbeat_q      <= wbeat_d;
      wbp_q        <= wbp_d;
      wr_out_q     <= wr_out_d;
      rd_out_q     <= rd_out_d;
      stall_q      <= stall_d;
      idle_q       <= idle_d;
      err_sticky_q <= err_sticky_d;
      err_pulse_q  <= err_pulse_d;
      err_first_q  <= err_first_d;
      err_count_q  <= err_count_d;
    end
  end

  assign err_sticky     = err_sticky_q;
  assign err_pulse      = err_pulse_q;
  assign err_first      = err_first_q;
  assign err_count      = err_count_q;
  assign wr_outstanding = wr_out_q;
  assign rd_outstanding = rd_out_q;
  assign dbg_fifo_cnt   = fifo_cnt_q;
  assign dbg_wbeat      = wbeat_q;

endmodule

// File: tb/tb_axi4_protocol_checker.sv
// Directed testbench for axi4_protocol_checker (MAX_OUTSTANDING=8,
// MAX_STALL=4, TIMEOUT=16). Inputs change 1 ns after each rising edge and
// outputs are sampled there, so each check sees the result of the edge
// just taken.
module tb_axi4_protocol_checker;

  logic        aclk = 1'b0;
  logic        areset_n, chk_en;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize;
  logic [7:0]  err_sticky;
  logic        err_pulse;
  logic [2:0]  err_first;
  logic [15:0] err_count;
  logic [3:0]  wr_outstanding, rd_outstanding, dbg_fifo_cnt;
  logic [8:0]  dbg_wbeat;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axi4_protocol_checker #(
    .DATA_W(64), .MAX_OUTSTANDING(8), .MAX_STALL(4), .TIMEOUT(16), .CNT_W(16)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .chk_en(chk_en),
    .awvalid(awvalid), .awready(awready), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .err_sticky(err_sticky), .err_pulse(err_pulse), .err_first(err_first),
    .err_count(err_count), .wr_outstanding(wr_outstanding),
    .rd_outstanding(rd_outstanding), .dbg_fifo_cnt(dbg_fifo_cnt),
    .dbg_wbeat(dbg_wbeat)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_bus();
    awvalid = 0; wvalid = 0; bvalid = 0; arvalid = 0; rvalid = 0;
    awready = 1; wready = 1; bready = 1; arready = 1; rready = 1;
    wlast = 0; rlast = 0; awlen = 0; arlen = 0; awsize = 3'd3;
  endtask

  task automatic do_reset();
    idle_bus();
    chk_en = 1;
    areset_n = 0;
    step();
    areset_n = 1;
  endtask

  task automatic test_reset();
    idle_bus();
    chk_en = 1;
    areset_n = 0;
    step(); step();
    total++; if (err_sticky !== 8'h00) begin bad++; $display("FAIL reset_sticky got=%h exp=00", err_sticky); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", err_pulse); end
    total++; if (err_first !== 3'd0) begin bad++; $display("FAIL reset_first got=%0d exp=0", err_first); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    total++; if (wr_outstanding !== 4'd0) begin bad++; $display("FAIL reset_wr_out got=%0d exp=0", wr_outstanding); end
    total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL reset_rd_out got=%0d exp=0", rd_outstanding); end
    areset_n = 1;
  endtask

  task automatic test_legal();
    awvalid = 1; awlen = 8'd3; step(); awvalid = 0;
    total++; if (wr_outstanding !== 4'd1) begin bad++; $display("FAIL legal_wr_out_aw got=%0d exp=1", wr_outstanding); end
    for (int i = 0; i < 4; i++) begin
      wvalid = 1; wlast = (i == 3); step();
    end
    wvalid = 0; wlast = 0;
    total++; if (wr_outstanding !== 4'd1) begin bad++; $display("FAIL legal_wr_out_w got=%0d exp=1", wr_outstanding); end
    total++; if (dbg_fifo_cnt !== 4'd0) begin bad++; $display("FAIL legal_fifo_pop got=%0d exp=0", dbg_fifo_cnt); end
    bvalid = 1; step(); bvalid = 0;
    total++; if (wr_outstanding !== 4'd0) begin bad++; $display("FAIL legal_wr_out_b got=%0d exp=0", wr_outstanding); end
    total++; if (err_sticky !== 8'h00) begin bad++; $display("FAIL legal_sticky got=%h exp=00", err_sticky); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL legal_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_wlast_early();
    awvalid = 1; awlen = 8'd3; step(); awvalid = 0;
    wvalid = 1; wlast = 0; step();
    wlast = 1; step();
    wvalid = 0; wlast = 0;
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL early_pulse got=%b exp=1", err_pulse); end
    total++; if (err_sticky !== 8'h01) begin bad++; $display("FAIL early_sticky got=%h exp=01", err_sticky); end
    total++; if (err_first !== 3'd0) begin bad++; $display("FAIL early_first got=%0d exp=0", err_first); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL early_count got=%0d exp=1", err_count); end
    step();
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL early_pulse_clear got=%b exp=0", err_pulse); end
    // Next burst: AW len=1 with its first beat in the same cycle (bypass).
    awvalid = 1; awlen = 8'd1; wvalid = 1; wlast = 0; step(); awvalid = 0;
    total++; if (dbg_wbeat !== 9'd1) begin bad++; $display("FAIL bypass_wbeat got=%0d exp=1", dbg_wbeat); end
    wlast = 1; step(); wvalid = 0; wlast = 0;
    total++; if (wr_outstanding !== 4'd2) begin bad++; $display("FAIL next_wr_out got=%0d exp=2", wr_outstanding); end
    bvalid = 1; step(); step(); bvalid = 0;
    total++; if (wr_outstanding !== 4'd0) begin bad++; $display("FAIL next_wr_out_b got=%0d exp=0", wr_outstanding); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL next_count got=%0d exp=1", err_count); end
    total++; if (err_sticky !== 8'h01) begin bad++; $display("FAIL next_sticky got=%h exp=01", err_sticky); end
  endtask

  task automatic test_unexpected();
    do_reset();
    bvalid = 1; step(); bvalid = 0;
    total++; if (err_sticky !== 8'h08) begin bad++; $display("FAIL unexp_b_sticky got=%h exp=08", err_sticky); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL unexp_b_pulse got=%b exp=1", err_pulse); end
    rvalid = 1; rlast = 1; step(); rvalid = 0; rlast = 0;
    total++; if (err_sticky !== 8'h18) begin bad++; $display("FAIL unexp_r_sticky got=%h exp=18", err_sticky); end
    total++; if (err_count !== 16'd2) begin bad++; $display("FAIL unexp_count got=%0d exp=2", err_count); end
    total++; if (err_first !== 3'd3) begin bad++; $display("FAIL unexp_first got=%0d exp=3", err_first); end
    total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL unexp_rd_out got=%0d exp=0", rd_outstanding); end
  endtask

  task automatic test_multi();
    do_reset();
    wvalid = 1; wlast = 1; bvalid = 1; step();
    wvalid = 0; wlast = 0; bvalid = 0;
    total++; if (err_sticky !== 8'h0C) begin bad++; $display("FAIL multi_sticky got=%h exp=0c", err_sticky); end
    total++; if (err_first !== 3'd2) begin bad++; $display("FAIL multi_first got=%0d exp=2", err_first); end
    total++; if (err_count !== 16'd2) begin bad++; $display("FAIL multi_count got=%0d exp=2", err_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    arvalid = 1; arlen = 8'd0;
    for (int i = 0; i < 8; i++) step();
    total++; if (rd_outstanding !== 4'd8) begin bad++; $display("FAIL ovf_rd_out8 got=%0d exp=8", rd_outstanding); end
    total++; if (err_sticky !== 8'h00) begin bad++; $display("FAIL ovf_sticky8 got=%h exp=00", err_sticky); end
    step(); arvalid = 0;
    total++; if (err_sticky !== 8'h20) begin bad++; $display("FAIL ovf_sticky9 got=%h exp=20", err_sticky); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", err_pulse); end
    total++; if (rd_outstanding !== 4'd8) begin bad++; $display("FAIL ovf_rd_out9 got=%0d exp=8", rd_outstanding); end
    rvalid = 1; rlast = 1; step(); rvalid = 0; rlast = 0;
    total++; if (rd_outstanding !== 4'd7) begin bad++; $display("FAIL ovf_rd_drain got=%0d exp=7", rd_outstanding); end
  endtask

  task automatic test_stall();
    int pulses = 0;
    int at = -1;
    do_reset();
    awvalid = 1; awready = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (err_pulse) begin pulses++; at = i; end
    end
    awvalid = 0; awready = 1;
    total++; if (pulses !== 1) begin bad++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    total++; if (at !== 4) begin bad++; $display("FAIL stall_cycle got=%0d exp=4", at); end
    total++; if (err_sticky !== 8'h40) begin bad++; $display("FAIL stall_sticky got=%h exp=40", err_sticky); end
    total++; if (err_first !== 3'd6) begin bad++; $display("FAIL stall_first got=%0d exp=6", err_first); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int at = -1;
    do_reset();
    arvalid = 1; step(); arvalid = 0;
    total++; if (rd_outstanding !== 4'd1) begin bad++; $display("FAIL to_rd_out got=%0d exp=1", rd_outstanding); end
    for (int i = 1; i <= 40; i++) begin
      step();
      if (err_pulse) begin pulses++; at = i; end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
    total++; if (at !== 16) begin bad++; $display("FAIL to_cycle got=%0d exp=16", at); end
    total++; if (err_sticky !== 8'h80) begin bad++; $display("FAIL to_sticky got=%h exp=80", err_sticky); end
    rvalid = 1; rlast = 1; step(); rvalid = 0; rlast = 0;
    total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL to_rd_drain got=%0d exp=0", rd_outstanding); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    awvalid = 1; awlen = 8'd7; bvalid = 1; arvalid = 1; step();
    awvalid = 0; bvalid = 0; arvalid = 0;
    wvalid = 1; wlast = 0; step();
    total++; if (err_sticky !== 8'h08) begin bad++; $display("FAIL mid_pre_sticky got=%h exp=08", err_sticky); end
    areset_n = 0; step();
    total++; if (err_sticky !== 8'h00) begin bad++; $display("FAIL mid_sticky got=%h exp=00", err_sticky); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL mid_pulse got=%b exp=0", err_pulse); end
    total++; if (err_first !== 3'd0) begin bad++; $display("FAIL mid_first got=%0d exp=0", err_first); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", err_count); end
    total++; if (wr_outstanding !== 4'd0) begin bad++; $display("FAIL mid_wr_out got=%0d exp=0", wr_outstanding); end
    total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL mid_rd_out got=%0d exp=0", rd_outstanding); end
    // The burst in flight was discarded, so this beat has no AW.
    areset_n = 1; wlast = 1; step(); wvalid = 0; wlast = 0;
    total++; if (err_sticky !== 8'h04) begin bad++; $display("FAIL mid_after_sticky got=%h exp=04", err_sticky); end
    total++; if (err_first !== 3'd2) begin bad++; $display("FAIL mid_after_first got=%0d exp=2", err_first); end
  endtask

  task automatic test_mask();
    do_reset();
    chk_en = 0;
    awvalid = 1; awlen = 8'd1; step(); awvalid = 0;
    wvalid = 1; wlast = 0; step(); step(); wvalid = 0;
    total++; if (err_sticky !== 8'h00) begin bad++; $display("FAIL mask_sticky got=%h exp=00", err_sticky); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL mask_count got=%0d exp=0", err_count); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL mask_pulse got=%b exp=0", err_pulse); end
    total++; if (dbg_fifo_cnt !== 4'd0) begin bad++; $display("FAIL mask_fifo_pop got=%0d exp=0", dbg_fifo_cnt); end
    chk_en = 1;
    wvalid = 1; wlast = 1; step(); wvalid = 0; wlast = 0;
    total++; if (err_sticky !== 8'h04) begin bad++; $display("FAIL mask_after_sticky got=%h exp=04", err_sticky); end
    total++; if (err_first !== 3'd2) begin bad++; $display("FAIL mask_after_first got=%0d exp=2", err_first); end
    total++; if (wr_outstanding !== 4'd1) begin bad++; $display("FAIL mask_wr_out got=%0d exp=1", wr_outstanding); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_wlast_early();
    test_unexpected();
    test_multi();
    test_overflow();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_mask();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before test sequence completed");
    $fatal(1);
  end

endmodule
